// File: rtl/tx_module.sv
// UART transmitter: frames a latched payload as start, 5..8 data bits (LSB first),
// optional even parity and 1..4 stop bits, each bit lasting 16 baud ticks.
module tx_module #(
    parameter int   MAX_UART_DATA_W = 8,
    parameter int   STOP_CONF_WIDTH = 2,
    parameter int   DATA_CONF_WIDTH = 2,
    parameter logic LINE_IDLE       = 1'b0
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     baud_en_i,
    input  logic                                     tx_en_i,
    input  logic                                     tx_start_i,
    input  logic [MAX_UART_DATA_W-1:0]               tx_data_i,
    input  logic [DATA_CONF_WIDTH+STOP_CONF_WIDTH:0] tx_conf_i,
    output logic                                     tx_ready_o,
    output logic                                     busy_o,
    output logic                                     tx_done_o,
    output logic                                     uart_tx_o
);

    localparam int CONF_W = DATA_CONF_WIDTH + STOP_CONF_WIDTH + 1;
    localparam int BIT_W  = $clog2(MAX_UART_DATA_W) + 1;

    localparam logic [2:0] ST_RESET      = 3'd0;
    localparam logic [2:0] ST_IDLE       = 3'd1;
    localparam logic [2:0] ST_SEND_START = 3'd2;
    localparam logic [2:0] ST_SEND_DATA  = 3'd3;
    localparam logic [2:0] ST_SEND_PAR   = 3'd4;
    localparam logic [2:0] ST_SEND_STOP  = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;

    logic [2:0]                 state_q, state_d;
    logic [3:0]                 sample_cnt_q, sample_cnt_d;
    logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [MAX_UART_DATA_W-1:0] data_q, data_d;
    logic [CONF_W-1:0]          conf_q, conf_d;
    logic                       uart_tx_q, uart_tx_d;

    logic                       in_frame;
    logic                       tick_end;
    logic [BIT_W-1:0]           last_data_idx;
    logic [BIT_W-1:0]           last_stop_idx;
    logic [MAX_UART_DATA_W-1:0] data_mask;
    logic [MAX_UART_DATA_W-1:0] data_shift;

    assign in_frame      = (state_q == ST_SEND_START) || (state_q == ST_SEND_DATA) ||
                           (state_q == ST_SEND_PAR)   || (state_q == ST_SEND_STOP);
    assign tick_end      = baud_en_i && (sample_cnt_q == 4'hF);
    assign last_data_idx = BIT_W'(conf_q[CONF_W-1 -: DATA_CONF_WIDTH]) + BIT_W'(4);
    assign last_stop_idx = BIT_W'(conf_q[1 +: STOP_CONF_WIDTH]);

    // Bits above the configured width are cleared at accept, so parity can XOR the whole word.
    always_comb begin
        for (int i = 0; i < MAX_UART_DATA_W; i++) begin
            data_mask[i] = (i < 5 + int'(tx_conf_i[CONF_W-1 -: DATA_CONF_WIDTH]));
        end
    end

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        conf_d       = conf_q;

        if (in_frame && baud_en_i) begin
            sample_cnt_d = sample_cnt_q + 4'd1;
        end

        case (state_q)
            ST_RESET: begin
                if (tx_en_i) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (tx_start_i) begin
                    state_d      = ST_SEND_START;
                    data_d       = tx_data_i & data_mask;
                    conf_d       = tx_conf_i;
                    sample_cnt_d = 4'd0;
                    bit_cnt_d    = '0;
                end else if (!tx_en_i) begin
                    state_d = ST_RESET;
                end
            end
            ST_SEND_START: begin
                if (tick_end) begin
                    state_d   = ST_SEND_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_SEND_DATA: begin
                if (tick_end) begin
                    if (bit_cnt_q == last_data_idx) begin
                        bit_cnt_d = '0;
                        state_d   = conf_q[0] ? ST_SEND_PAR : ST_SEND_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_SEND_PAR: begin
                if (tick_end) begin
                    state_d   = ST_SEND_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_SEND_STOP: begin
                if (tick_end) begin
                    if (bit_cnt_q == last_stop_idx) begin
                        state_d   = ST_DONE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                sample_cnt_d = 4'd0;
                state_d      = tx_en_i ? ST_IDLE : ST_RESET;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Line level follows the next state so the registered output lines up with the state.
    always_comb begin
        data_shift = data_d >> bit_cnt_d;
        case (state_d)
            ST_SEND_START: uart_tx_d = ~LINE_IDLE;
            ST_SEND_DATA:  uart_tx_d = data_shift[0];
            ST_SEND_PAR:   uart_tx_d = ^data_d;
            default:       uart_tx_d = LINE_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the async reset also clears the
    // latched payload so a discarded frame leaves nothing behind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_RESET;
            sample_cnt_q <= 4'd0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            conf_q       <= '0;
            uart_tx_q    <= LINE_IDLE;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            conf_q       <= conf_d;
            uart_tx_q    <= uart_tx_d;
        end
    end

    assign tx_ready_o = (state_q == ST_IDLE);
    assign busy_o     = in_frame;
    assign tx_done_o  = (state_q == ST_DONE);
    assign uart_tx_o  = uart_tx_q;

endmodule

// File: tb/tb_tx_module.sv
// Bench for tx_module: a frame-level reference model (bit list plus tick count)
// is compared against the DUT every cycle, with directed and random stimulus.
module tb_tx_module;

    localparam logic LI = 1'b0;

    logic       clk_i      = 1'b0;
    logic       rst_i      = 1'b1;
    logic       baud_en_i  = 1'b0;
    logic       tx_en_i    = 1'b0;
    logic       tx_start_i = 1'b0;
    logic [7:0] tx_data_i  = 8'h00;
    logic [4:0] tx_conf_i  = 5'h00;
    logic       tx_ready_o;
    logic       busy_o;
    logic       tx_done_o;
    logic       uart_tx_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    tx_module #(
        .MAX_UART_DATA_W(8),
        .STOP_CONF_WIDTH(2),
        .DATA_CONF_WIDTH(2),
        .LINE_IDLE      (LI)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .baud_en_i (baud_en_i),
        .tx_en_i   (tx_en_i),
        .tx_start_i(tx_start_i),
        .tx_data_i (tx_data_i),
        .tx_conf_i (tx_conf_i),
        .tx_ready_o(tx_ready_o),
        .busy_o    (busy_o),
        .tx_done_o (tx_done_o),
        .uart_tx_o (uart_tx_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as the list of line levels in send order, one entry per bit.
    task automatic build_frame(input logic [7:0] d, input logic [4:0] c,
                               output logic [15:0] bits, output int nb);
        int   n   = 5 + int'(c[4:3]);
        int   s   = 1 + int'(c[2:1]);
        logic par = 1'b0;
        bits = '0;
        nb   = 0;
        bits[nb] = ~LI; nb++;
        for (int i = 0; i < n; i++) begin
            bits[nb] = d[i];
            par      = par ^ d[i];
            nb++;
        end
        if (c[0]) begin
            bits[nb] = par; nb++;
        end
        for (int i = 0; i < s; i++) begin
            bits[nb] = LI; nb++;
        end
    endtask

    typedef enum int {M_OFF, M_IDLE, M_FRAME, M_DONE} mode_t;
    mode_t       m_mode = M_OFF;
    logic [15:0] m_bits = '0;
    int          m_nbits = 0;
    int          m_ticks = 0;
    int          done_seen = 0;
    logic        exp_line;

    // Reference model steps on each edge from the inputs it saw, then outputs are compared.
    initial begin
        forever begin
            @(posedge clk_i);
            if (rst_i) begin
                m_mode = M_OFF;
            end else begin
                case (m_mode)
                    M_OFF:  if (tx_en_i) m_mode = M_IDLE;
                    M_IDLE: begin
                        if (tx_start_i) begin
                            build_frame(tx_data_i, tx_conf_i, m_bits, m_nbits);
                            m_ticks = 0;
                            m_mode  = M_FRAME;
                        end else if (!tx_en_i) begin
                            m_mode = M_OFF;
                        end
                    end
                    M_FRAME: begin
                        if (baud_en_i) begin
                            m_ticks++;
                            if (m_ticks == 16 * m_nbits) m_mode = M_DONE;
                        end
                    end
                    default: m_mode = tx_en_i ? M_IDLE : M_OFF;
                endcase
            end
            #1;
            exp_line = (m_mode == M_FRAME) ? m_bits[4'(m_ticks / 16)] : LI;
            check("ready", tx_ready_o, m_mode == M_IDLE);
            check("busy",  busy_o,     m_mode == M_FRAME);
            check("done",  tx_done_o,  m_mode == M_DONE);
            check("line",  uart_tx_o,  exp_line);
            if (tx_done_o) done_seen++;
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (tx_ready_o) break;
        end
        check("ready_wait", tx_ready_o, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [4:0] c, input int exp_ticks,
                              input bit poke, input bit rand_baud, input bit en_drop);
        int ticks = 0;
        int d0;
        bit got = 0;
        wait_ready();
        tx_start_i = 1'b1;
        tx_data_i  = d;
        tx_conf_i  = c;
        baud_en_i  = rand_baud ? 1'($urandom % 2) : 1'b1;
        @(negedge clk_i);
        d0         = done_seen;
        tx_start_i = 1'b0;
        tx_data_i  = 8'($urandom);
        tx_conf_i  = 5'($urandom);
        for (int k = 0; k < 4000; k++) begin
            if (tx_done_o) begin
                got = 1;
                break;
            end
            tx_start_i = poke && (k == 50);
            if (poke && k == 50) tx_data_i = 8'h55;
            if (en_drop && k == 30) tx_en_i = 1'b0;
            baud_en_i = rand_baud ? 1'($urandom % 2) : 1'b1;
            if (busy_o && baud_en_i) ticks++;
            @(negedge clk_i);
        end
        tx_start_i = 1'b0;
        check("frame_done_seen", got, 1'b1);
        check("frame_ticks", ticks, exp_ticks);
        check("done_pulses", done_seen - d0, 1);
    endtask

    initial begin
        logic [15:0] b;
        int          nb;
        int          d0;

        build_frame(8'hA5, 5'b11_00_0, b, nb);
        check("pin_a5_bits", b, 16'h014B);
        check("pin_a5_len", nb, 10);
        build_frame(8'h07, 5'b11_01_1, b, nb);
        check("pin_07_bits", b, 16'h020F);
        check("pin_07_len", nb, 12);
        build_frame(8'hFF, 5'b00_11_0, b, nb);
        check("pin_ff_bits", b, 16'h003F);
        check("pin_ff_len", nb, 10);

        repeat (3) @(negedge clk_i);
        check("rst_line",  uart_tx_o,  LI);
        check("rst_ready", tx_ready_o, 1'b0);
        check("rst_busy",  busy_o,     1'b0);
        check("rst_done",  tx_done_o,  1'b0);
        rst_i   = 1'b0;
        tx_en_i = 1'b1;

        send_frame(8'hA5, 5'b11_00_0, 160, 0, 0, 0);
        send_frame(8'h07, 5'b11_01_1, 192, 1, 0, 0);
        send_frame(8'hFF, 5'b00_11_0, 160, 0, 1, 0);

        // Reset in the middle of data bit 1 of an all-ones payload.
        wait_ready();
        tx_start_i = 1'b1;
        tx_data_i  = 8'hFF;
        tx_conf_i  = 5'b11_00_0;
        baud_en_i  = 1'b1;
        @(negedge clk_i);
        tx_start_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("pre_rst_line", uart_tx_o, 1'b1);
        d0    = done_seen;
        rst_i = 1'b1;
        #1;
        check("async_rst_line", uart_tx_o, LI);
        check("async_rst_busy", busy_o, 1'b0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        wait_ready();
        check("rst_no_done", done_seen - d0, 0);

        // Enable dropped mid-frame: frame completes, then the FSM parks in Reset.
        send_frame(8'h3C, 5'b10_00_1, 16 * (1 + 7 + 1 + 1), 0, 0, 1);
        @(negedge clk_i);
        check("en_drop_parked", tx_ready_o, 1'b0);
        tx_en_i = 1'b1;

        // Start held high: back-to-back frames.
        wait_ready();
        tx_start_i = 1'b1;
        tx_data_i  = 8'h96;
        tx_conf_i  = 5'b11_00_0;
        d0 = done_seen;
        repeat (500) @(negedge clk_i);
        tx_start_i = 1'b0;
        check("b2b_frames", done_seen - d0, 3);

        for (int c = 0; c < 32; c++) begin
            logic [4:0] cf;
            cf = 5'(c);
            send_frame(8'($urandom), cf,
                       16 * (1 + 5 + int'(cf[4:3]) + int'(cf[0]) + 1 + int'(cf[2:1])), 0, 1, 0);
        end

        for (int k = 0; k < 5000; k++) begin
            @(negedge clk_i);
            baud_en_i  = ($urandom % 3) == 0;
            tx_start_i = ($urandom % 16) == 0;
            tx_data_i  = 8'($urandom);
            tx_conf_i  = 5'($urandom);
            if (($urandom % 64) == 0) tx_en_i = ~tx_en_i;
            rst_i = ($urandom % 1500) == 0;
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tx_module.md
TX_MODULE -- requirements
Module: tx_module

Interface
REQ-001 SHALL have parameter MAX_UART_DATA_W, default 8, max data width.
REQ-002 SHALL have parameter STOP_CONF_WIDTH, default 2, stop-field width.
REQ-003 SHALL have parameter DATA_CONF_WIDTH, default 2, data-field width.
REQ-004 SHALL have parameter LINE_IDLE, default 1'b0, idle and stop level of the line; start level is ~LINE_IDLE.
REQ-005 SHALL have port clk_i  in  1  clock.
REQ-006 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port baud_en_i  in  1  16x-oversample tick enable, one clk wide.
REQ-008 SHALL have port tx_en_i  in  1  transmitter enable.
REQ-009 SHALL have port tx_start_i  in  1  request to send tx_data_i.
REQ-010 SHALL have port tx_data_i  in  MAX_UART_DATA_W  payload, LSB sent first.
REQ-011 SHALL have port tx_conf_i  in  5  {data[1:0], stop[1:0], parity_en}.
REQ-012 SHALL have port tx_ready_o  out  1  high when a request will be accepted.
REQ-013 SHALL have port busy_o  out  1  frame in progress.
REQ-014 SHALL have port tx_done_o  out  1  one-clk pulse at frame end.
REQ-015 SHALL have port uart_tx_o  out  1  serial line, registered.

Function
REQ-016 SHALL implement states Reset, Idle, SendStart, SendData, SendParity, SendStop, Done.
REQ-017 Reset->Idle when tx_en_i=1; Idle->Reset when tx_en_i=0 and no request is accepted.
REQ-018 tx_ready_o SHALL be 1 only in Idle.
REQ-019 An accept SHALL be a clk edge with tx_start_i=1 and tx_ready_o=1; it latches tx_data_i and tx_conf_i, enters SendStart, sets busy_o=1, and drops tx_ready_o on the following cycle.
REQ-020 Latched data and config SHALL be held constant for the whole frame; input changes mid-frame SHALL be ignored.
REQ-021 Data bit count SHALL be 5+data[1:0] (5..8); bits of tx_data_i above that count SHALL be ignored.
REQ-022 Stop bit count SHALL be 1+stop[1:0] (1..4).
REQ-023 The parity bit SHALL be sent only when parity_en=1, and SHALL equal XOR of the transmitted data bits (even parity).
REQ-024 Every bit SHALL last exactly 16 baud_en_i ticks, counted by a 4-bit sample counter that advances only on baud_en_i and wraps 15->0 at the bit boundary.
REQ-025 Line levels SHALL be: start ~LINE_IDLE, data bits as-is, parity as computed, stop LINE_IDLE, and LINE_IDLE in Reset, Idle and Done.
REQ-026 State transitions SHALL occur on the tick where the counter is 15: SendStart->SendData; SendData after last bit->SendParity if parity_en else SendStop; SendStop after last stop bit->Done.
REQ-027 Done SHALL last one clk, assert tx_done_o for that clk, clear busy_o, then go to Idle if tx_en_i=1, else Reset.
REQ-028 tx_en_i deasserted mid-frame SHALL NOT abort the frame; the FSM goes to Reset after Done.
REQ-029 tx_start_i while busy SHALL be ignored, with no queuing.
REQ-030 tx_start_i held high through Done SHALL be accepted in Idle on the next edge, giving back-to-back frames with only the Done/Idle cycles of LINE_IDLE between them.
REQ-031 Total frame length SHALL be 16*(1+N+P+S) baud ticks, where N is data bits, P is parity bits (0/1) and S is stop bits.
REQ-032 An unencoded state SHALL go to Reset.

Reset
REQ-033 While rst_i=1: state=Reset, uart_tx_o=LINE_IDLE, tx_ready_o=0, busy_o=0, tx_done_o=0, counters=0, latched data/config=0.
REQ-034 rst_i asserted mid-frame SHALL force the line to LINE_IDLE immediately (asynchronously) and discard the frame with no tx_done_o pulse.

Verification
REQ-035 conf=5'b11_00_0, data 8'hA5, baud_en every clk -> line start(1), 1,0,1,0,0,1,0,1, stop(0); 160 ticks; one tx_done_o pulse.
REQ-036 conf=5'b11_01_1, data 8'h07 -> 8 data bits, parity bit 1, 2 stop bits; frame = 192 ticks.
REQ-037 conf=5'b00_11_0, data 8'hFF -> 5 data bits all 1 and 4 stop bits, 10 bits total; upper data bits never driven.
REQ-038 tx_start_i pulsed mid-frame with new data -> ignored; line matches the original frame; tx_ready_o=0 throughout.
REQ-039 rst_i pulsed in SendData -> uart_tx_o=LINE_IDLE within the same cycle; no tx_done_o; after release and tx_en_i=1 the FSM reaches Idle, tx_ready_o=1.
REQ-040 Cross-check with the team receiver, same conf, sweeping all 32 conf values with random data -> receiver rx_data_o equals sent data, parity_error_o=0.
